// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined signed adder/subtractor.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Widest operand the saturation helper supports.
  localparam int unsigned MAX_W = 64;
  localparam int unsigned EXT_W = MAX_W + 1;
  localparam int unsigned IDX_W = $clog2(EXT_W);

  // Operand/result width pairing the datapath knows how to build.
  function automatic bit widths_ok(input int unsigned arg_w, input int unsigned res_w);
    return (arg_w >= 2) && (arg_w <= MAX_W) && ((res_w == arg_w) || (res_w == arg_w + 1));
  endfunction

  // Clamp an overflowed (w+1)-bit sum to the w-bit extreme its sign bit points at.
  function automatic logic [MAX_W-1:0] sat_clamp(input logic [EXT_W-1:0] tmp, input int unsigned w);
    logic [MAX_W-1:0] min_neg;
    logic [IDX_W-1:0] sign_idx;
    min_neg  = MAX_W'(1) << (w - 1);
    sign_idx = IDX_W'(w);
    return tmp[sign_idx] ? min_neg : (min_neg - MAX_W'(1));
  endfunction

endpackage

// File: rtl/addsub_pipe_slice.sv
// One valid/ready register slice; loads when empty or when draining in the same cycle.
module pipe_slice #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  input  logic         out_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic load_c;

  assign load_c = in_vld && (!out_vld || out_rdy);

  // Valid bit and payload; payload only changes on a load, so it holds during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (load_c) begin
      out_vld  <= 1'b1;
      out_data <= in_data;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined signed add/sub with valid/ready flow control, optional saturation
// and a saturating overflow event counter.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned ARG_WIDTH = 32,
  parameter int unsigned RES_WIDTH = ARG_WIDTH + 1,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arg_vld,
  output logic                        arg_rdy,
  input  logic                        op,
  input  logic signed [ARG_WIDTH-1:0] a,
  input  logic signed [ARG_WIDTH-1:0] b,
  output logic                        res_vld,
  input  logic                        res_rdy,
  output logic        [RES_WIDTH-1:0] res,
  output logic                        overflow,
  output logic        [CNT_WIDTH-1:0] ovf_cnt,
  input  logic                        cnt_clr
);

  localparam int unsigned SUM_W = ARG_WIDTH + 1;
  localparam int unsigned PAY_W = RES_WIDTH + 1;

  if (!widths_ok(ARG_WIDTH, RES_WIDTH)) begin : g_bad_width
    $error("addsub_pipe: RES_WIDTH must be ARG_WIDTH or ARG_WIDTH+1, ARG_WIDTH in 2..64");
  end
  if ((STAGES < 1) || (STAGES > 4)) begin : g_bad_stages
    $error("addsub_pipe: STAGES must be 1..4");
  end

  logic signed [SUM_W-1:0] a_x, b_x, sum_c;
  logic                    ovf_c;
  logic    [RES_WIDTH-1:0] res_c;
  logic       [STAGES:1]   stage_vld;
  logic       [STAGES:0]   rdy_chain;
  logic      [PAY_W-1:0]   stage_pay [STAGES+1];

  // Full-precision sum from sign-extended operands.
  always_comb begin
    a_x   = SUM_W'(a);
    b_x   = SUM_W'(b);
    sum_c = (op_e'(op) == OP_SUB) ? (a_x - b_x) : (a_x + b_x);
    ovf_c = sum_c[ARG_WIDTH] ^ sum_c[ARG_WIDTH-1];
  end

  if (RES_WIDTH == SUM_W) begin : g_full
    assign res_c = sum_c;
  end else if (SATURATE != 0) begin : g_sat
    assign res_c = ovf_c ? RES_WIDTH'(sat_clamp(EXT_W'(sum_c), ARG_WIDTH))
                         : sum_c[RES_WIDTH-1:0];
  end else begin : g_wrap
    assign res_c = sum_c[RES_WIDTH-1:0];
  end

  assign stage_pay[0] = {res_c, ovf_c};

  // Ready ripples back from the consumer: a stage can take data if it, or anything after it, frees up.
  always_comb begin
    rdy_chain         = '0;
    rdy_chain[STAGES] = res_rdy;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      rdy_chain[i] = !stage_vld[i+1] || rdy_chain[i+1];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic in_vld;
    if (i == 0) begin : g_head
      assign in_vld = arg_vld;
    end else begin : g_link
      assign in_vld = stage_vld[i];
    end

    pipe_slice #(.W(PAY_W)) u_slice (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (in_vld),
      .in_data  (stage_pay[i]),
      .out_rdy  (rdy_chain[i+1]),
      .out_vld  (stage_vld[i+1]),
      .out_data (stage_pay[i+1])
    );
  end

  assign arg_rdy             = !rst && rdy_chain[0];
  assign res_vld             = stage_vld[STAGES];
  assign {res, overflow}     = stage_pay[STAGES];

  // Count delivered overflow results; clear wins over a same-cycle event, count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      ovf_cnt <= '0;
    end else if (res_vld && res_rdy && overflow && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: three configurations sharing operand/consumer signals.
module tb_addsub_pipe;

  typedef struct {
    logic [8:0] r9;
    logic [7:0] rw;
    logic [7:0] rs;
    logic       ovf;
    int         stamp;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    logic [8:0] e9;
    logic [7:0] ew;
    logic [7:0] es;
    logic       eo;
  } vec_t;

  logic       clk, rst, res_rdy, cnt_clr, op;
  logic [7:0] in_a, in_b;
  logic [2:0] vld;

  logic       arg_rdy_w, res_vld_w, overflow_w;
  logic [8:0] res_w;
  logic [15:0] ovf_cnt_w;
  logic       arg_rdy_r, res_vld_r, overflow_r;
  logic [7:0] res_r;
  logic [15:0] ovf_cnt_r;
  logic       arg_rdy_s, res_vld_s, overflow_s;
  logic [7:0] res_s;
  logic [1:0] ovf_cnt_s;

  addsub_pipe #(.ARG_WIDTH(8), .RES_WIDTH(9), .STAGES(2), .SATURATE(0), .CNT_WIDTH(16)) u_w (
    .clk(clk), .rst(rst), .arg_vld(vld[0]), .arg_rdy(arg_rdy_w), .op(op), .a(in_a), .b(in_b),
    .res_vld(res_vld_w), .res_rdy(res_rdy), .res(res_w), .overflow(overflow_w),
    .ovf_cnt(ovf_cnt_w), .cnt_clr(cnt_clr));

  addsub_pipe #(.ARG_WIDTH(8), .RES_WIDTH(8), .STAGES(1), .SATURATE(0), .CNT_WIDTH(16)) u_r (
    .clk(clk), .rst(rst), .arg_vld(vld[1]), .arg_rdy(arg_rdy_r), .op(op), .a(in_a), .b(in_b),
    .res_vld(res_vld_r), .res_rdy(res_rdy), .res(res_r), .overflow(overflow_r),
    .ovf_cnt(ovf_cnt_r), .cnt_clr(cnt_clr));

  addsub_pipe #(.ARG_WIDTH(8), .RES_WIDTH(8), .STAGES(3), .SATURATE(1), .CNT_WIDTH(2)) u_s (
    .clk(clk), .rst(rst), .arg_vld(vld[2]), .arg_rdy(arg_rdy_s), .op(op), .a(in_a), .b(in_b),
    .res_vld(res_vld_s), .res_rdy(res_rdy), .res(res_s), .overflow(overflow_s),
    .ovf_cnt(ovf_cnt_s), .cnt_clr(cnt_clr));

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   mcnt_w = 0;
  int   dlv_w = 0;
  int   acc_s = 0;
  bit   started = 0;
  bit   lat_chk = 0;
  bit   rnd_on = 0;
  exp_t cur_exp;
  exp_t q_w[$], q_r[$], q_s[$];
  exp_t e_w, e_r, e_s;
  vec_t tbl[12];
  logic [7:0] held;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] x, input logic [7:0] y, input logic o);
    logic [8:0] t;
    exp_t r;
    t     = o ? ({x[7], x} - {y[7], y}) : ({x[7], x} + {y[7], y});
    r.r9  = t;
    r.ovf = t[8] ^ t[7];
    r.rw  = t[7:0];
    r.rs  = r.ovf ? (t[8] ? 8'h80 : 8'h7F) : t[7:0];
    r.stamp = 0;
    return r;
  endfunction

  function automatic exp_t from_vec(input vec_t v);
    exp_t r;
    r.r9 = v.e9; r.rw = v.ew; r.rs = v.es; r.ovf = v.eo; r.stamp = 0;
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on delivery; reset discards everything in flight.
  always @(negedge clk) begin
    if (rst) begin
      q_w.delete(); q_r.delete(); q_s.delete();
      mcnt_w = 0;
    end else if (started) begin
      chk("w_ovf_cnt", ovf_cnt_w, mcnt_w);
      if (vld[0] && arg_rdy_w) begin e_w = cur_exp; e_w.stamp = cyc; q_w.push_back(e_w); end
      if (vld[1] && arg_rdy_r) begin e_r = cur_exp; e_r.stamp = cyc; q_r.push_back(e_r); end
      if (vld[2] && arg_rdy_s) begin e_s = cur_exp; e_s.stamp = cyc; q_s.push_back(e_s); acc_s++; end
      if (cnt_clr) mcnt_w = 0;
      if (res_vld_w && res_rdy) begin
        dlv_w++;
        if (q_w.size() == 0) begin
          errors++; checks++;
          $display("FAIL w_extra: unexpected result 0x%0h, none expected", res_w);
        end else begin
          e_w = q_w.pop_front();
          chk("w_res", res_w, e_w.r9);
          chk("w_ovf", overflow_w, e_w.ovf);
          if (lat_chk) chk("w_latency", cyc - e_w.stamp, 2);
          if (!cnt_clr && e_w.ovf) mcnt_w++;
        end
      end
      if (res_vld_r && res_rdy) begin
        if (q_r.size() == 0) begin
          errors++; checks++;
          $display("FAIL r_extra: unexpected result 0x%0h, none expected", res_r);
        end else begin
          e_r = q_r.pop_front();
          chk("r_res", res_r, e_r.rw);
          chk("r_ovf", overflow_r, e_r.ovf);
          if (lat_chk) chk("r_latency", cyc - e_r.stamp, 1);
        end
      end
      if (res_vld_s && res_rdy) begin
        if (q_s.size() == 0) begin
          errors++; checks++;
          $display("FAIL s_extra: unexpected result 0x%0h, none expected", res_s);
        end else begin
          e_s = q_s.pop_front();
          chk("s_res", res_s, e_s.rs);
          chk("s_ovf", overflow_s, e_s.ovf);
          if (lat_chk) chk("s_latency", cyc - e_s.stamp, 3);
        end
      end
    end
  end

  // Present one operand pair to the masked DUTs and hold it until each has accepted.
  task automatic send(input logic [2:0] m, input logic [7:0] ta, input logic [7:0] tb,
                      input logic top, input exp_t e, output int n);
    logic [2:0] acc;
    in_a = ta; in_b = tb; op = top; cur_exp = e; vld = m; n = 0;
    while ((vld != 3'b000) && (n < 300)) begin
      @(negedge clk);
      acc = vld & {arg_rdy_s, arg_rdy_r, arg_rdy_w};
      @(posedge clk); #1;
      vld = vld & ~acc;
      n++;
    end
    if (vld != 3'b000) begin
      errors++; checks++;
      $display("FAIL send_timeout: operands still pending mask=%b", vld);
      vld = 3'b000;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (((q_w.size() + q_r.size() + q_s.size()) != 0) && (n < 2000)) begin
      @(posedge clk);
      n++;
    end
    #1;
    if ((q_w.size() + q_r.size() + q_s.size()) != 0) begin
      errors++; checks++;
      $display("FAIL drain_timeout: %0d results never delivered", q_w.size() + q_r.size() + q_s.size());
    end
  endtask

  initial begin
    int n, tot, base;
    logic [7:0] ra, rb;
    logic ro;

    tbl[0]  = '{8'd100, 8'd27,  1'b0, 9'h07F, 8'h7F, 8'h7F, 1'b0};
    tbl[1]  = '{8'd100, 8'd28,  1'b0, 9'h080, 8'h80, 8'h7F, 1'b1};
    tbl[2]  = '{8'h80,  8'h01,  1'b1, 9'h17F, 8'h7F, 8'h80, 1'b1};
    tbl[3]  = '{8'h7F,  8'hFF,  1'b1, 9'h080, 8'h80, 8'h7F, 1'b1};
    tbl[4]  = '{8'h80,  8'h80,  1'b0, 9'h100, 8'h00, 8'h80, 1'b1};
    tbl[5]  = '{8'hFF,  8'hFF,  1'b0, 9'h1FE, 8'hFE, 8'hFE, 1'b0};
    tbl[6]  = '{8'd5,   8'd9,   1'b1, 9'h1FC, 8'hFC, 8'hFC, 1'b0};
    tbl[7]  = '{8'h00,  8'h00,  1'b0, 9'h000, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{8'h80,  8'h7F,  1'b1, 9'h101, 8'h01, 8'h80, 1'b1};
    tbl[9]  = '{8'h7F,  8'h7F,  1'b0, 9'h0FE, 8'hFE, 8'h7F, 1'b1};
    tbl[10] = '{8'hCE,  8'hCE,  1'b1, 9'h000, 8'h00, 8'h00, 1'b0};
    tbl[11] = '{8'hFF,  8'h7F,  1'b1, 9'h180, 8'h80, 8'h80, 1'b0};

    rst = 1'b1; vld = 3'b000; res_rdy = 1'b0; cnt_clr = 1'b0;
    op = 1'b0; in_a = 8'h00; in_b = 8'h00; cur_exp = mk(8'h00, 8'h00, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arg_rdy_w", arg_rdy_w, 0);
    chk("rst_res_vld_w", res_vld_w, 0);
    chk("rst_res_w", res_w, 0);
    chk("rst_overflow_w", overflow_w, 0);
    chk("rst_ovf_cnt_w", ovf_cnt_w, 0);
    chk("rst_res_vld_s", res_vld_s, 0);
    chk("rst_ovf_cnt_s", ovf_cnt_s, 0);
    @(posedge clk); #1;
    rst = 1'b0; started = 1'b1;
    @(negedge clk);
    chk("post_rst_arg_rdy_w", arg_rdy_w, 1);
    chk("post_rst_arg_rdy_r", arg_rdy_r, 1);
    chk("post_rst_arg_rdy_s", arg_rdy_s, 1);
    @(posedge clk); #1;

    // Table vectors applied to all three configurations, latency checked
    res_rdy = 1'b1; lat_chk = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(3'b111, tbl[i].a, tbl[i].b, tbl[i].op, from_vec(tbl[i]), n);
    end
    wait_idle();
    lat_chk = 1'b0;

    // Backpressure on the 3-stage saturating unit
    res_rdy = 1'b0;
    base = acc_s;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          ra = 8'(i * 29 + 90); rb = 8'(i * 17); ro = 1'(i % 2);
          send(3'b100, ra, rb, ro, mk(ra, rb, ro), n);
        end
      end
      begin
        repeat (4) @(negedge clk);
        held = res_s;
        chk("bp_arg_rdy_low", arg_rdy_s, 0);
        chk("bp_res_vld", res_vld_s, 1);
        @(negedge clk);
        chk("bp_hold1", res_s, held);
        @(negedge clk);
        chk("bp_hold2", res_s, held);
        chk("bp_accepted", acc_s - base, 3);
        chk("bp_arg_rdy_low2", arg_rdy_s, 0);
        @(posedge clk); #1;
        res_rdy = 1'b1;
      end
    join
    wait_idle();
    chk("bp_total", acc_s - base, 10);

    // Random valid/ready traffic on the 2-stage unit
    base = dlv_w;
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          ra = 8'($urandom); rb = 8'($urandom); ro = 1'($urandom_range(0, 1));
          send(3'b001, ra, rb, ro, mk(ra, rb, ro), n);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          res_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    res_rdy = 1'b1;
    wait_idle();
    chk("rnd_delivered", dlv_w - base, 1000);

    // Full throughput with both sides ready
    tot = 0;
    for (int i = 0; i < 20; i++) begin
      ra = 8'(i * 11 + 100); rb = 8'(i * 3);
      send(3'b001, ra, rb, 1'b0, mk(ra, rb, 1'b0), n);
      tot += n;
    end
    chk("thru_cycles", tot, 20);
    wait_idle();

    // Reset with two transactions in flight
    res_rdy = 1'b0;
    send(3'b001, 8'd100, 8'd100, 1'b0, mk(8'd100, 8'd100, 1'b0), n);
    send(3'b001, 8'h80, 8'd1, 1'b1, mk(8'h80, 8'd1, 1'b1), n);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_arg_rdy", arg_rdy_w, 0);
    @(posedge clk); #1;
    rst = 1'b0; res_rdy = 1'b1;
    @(negedge clk);
    chk("midrst_res_vld", res_vld_w, 0);
    chk("midrst_ovf_cnt", ovf_cnt_w, 0);
    chk("midrst_arg_rdy_back", arg_rdy_w, 1);
    base = dlv_w;
    repeat (6) @(negedge clk);
    chk("midrst_no_stale", dlv_w - base, 0);
    @(posedge clk); #1;

    // Saturating 2-bit overflow counter
    for (int k = 0; k < 5; k++) begin
      send(3'b100, 8'd127, 8'd1, 1'b0, mk(8'd127, 8'd1, 1'b0), n);
      wait_idle();
      @(negedge clk);
      chk("cnt_step", ovf_cnt_s, (k < 3) ? k + 1 : 3);
      @(posedge clk); #1;
    end

    // Clear coincident with an overflowing delivery
    res_rdy = 1'b0;
    send(3'b100, 8'h80, 8'h80, 1'b0, mk(8'h80, 8'h80, 1'b0), n);
    n = 0;
    do begin @(negedge clk); n++; end while (!res_vld_s && (n < 20));
    chk("clr_res_vld", res_vld_s, 1);
    @(posedge clk); #1;
    cnt_clr = 1'b1; res_rdy = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr_priority", ovf_cnt_s, 0);
    chk("cnt_clr_queue_empty", q_s.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
